// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator: widths, event record,
// FSM encoding and the saturating age helper.
package voice_allocator_pkg;
   localparam int N_OSCILLATORS = 4;
   localparam int FIXED_POINT   = 16;
   localparam int FREQ_W        = 32;
   localparam int NOTE_W        = 7;
   localparam int AGE_W         = 8;

   localparam logic [AGE_W-1:0] VOICE_AGE_MAX = '1;

   typedef struct packed {
      logic              on;
      logic [NOTE_W-1:0] note;
      logic [FREQ_W-1:0] freq;
   } voice_evt_t;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_APPLY} va_state_t;

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      return (a == VOICE_AGE_MAX) ? a : a + 1'b1;
   endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between the protocol decoder (master) and the allocator (slave).
interface voice_allocator_if;
   import voice_allocator_pkg::*;

   logic              evt_valid;
   logic              evt_ready;
   logic              evt_on;
   logic [NOTE_W-1:0] evt_note;
   logic [FREQ_W-1:0] evt_freq;

   modport master (output evt_valid, evt_on, evt_note, evt_freq, input evt_ready);
   modport slave  (input evt_valid, evt_on, evt_note, evt_freq, output evt_ready);
endinterface

// File: rtl/voice_allocator_scan_unit.sv
// Walks the voices one per cycle, remembering the first matching note, the first
// free voice and the oldest voice (ties keep the lowest index).
module voice_allocator_scan_unit
   import voice_allocator_pkg::*;
#(
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clear,
   input  logic             i_step,
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_cur_enabled,
   input  logic             i_cur_match,
   input  logic [AGE_W-1:0] i_cur_age,
   output logic             o_match_vld,
   output logic [IDX_W-1:0] o_match_idx,
   output logic             o_free_vld,
   output logic [IDX_W-1:0] o_free_idx,
   output logic [IDX_W-1:0] o_oldest_idx
);
   logic             r_match_vld, r_free_vld;
   logic [IDX_W-1:0] r_match_idx, r_free_idx, r_oldest_idx;
   logic [AGE_W-1:0] r_oldest_age;

   // Oldest starts at idx 0 / age 0; only a strictly greater age moves it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_match_vld  <= 1'b0;
         r_match_idx  <= '0;
         r_free_vld   <= 1'b0;
         r_free_idx   <= '0;
         r_oldest_idx <= '0;
         r_oldest_age <= '0;
      end else if (i_clear) begin
         r_match_vld  <= 1'b0;
         r_match_idx  <= '0;
         r_free_vld   <= 1'b0;
         r_free_idx   <= '0;
         r_oldest_idx <= '0;
         r_oldest_age <= '0;
      end else if (i_step) begin
         if (i_cur_match && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= i_idx;
         end
         if (!i_cur_enabled && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= i_idx;
         end
         if (i_cur_age > r_oldest_age) begin
            r_oldest_age <= i_cur_age;
            r_oldest_idx <= i_idx;
         end
      end
   end

   assign o_match_vld  = r_match_vld;
   assign o_match_idx  = r_match_idx;
   assign o_free_vld   = r_free_vld;
   assign o_free_idx   = r_free_idx;
   assign o_oldest_idx = r_oldest_idx;
endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on/off events to oscillator voices (retrigger, first free, or steal
// the oldest) and drives per-voice enable, envelope reset, freq, note and count.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int N_VOICES = N_OSCILLATORS
) (
   input  logic                             clk,
   input  logic                             rstn,
   voice_allocator_if.slave                 evt,
   input  logic                             i_all_off,
   output logic [N_VOICES-1:0]              o_voice_enable,
   output logic [N_VOICES-1:0]              o_voice_reset,
   output logic [N_VOICES-1:0][FREQ_W-1:0]  o_voice_freq,
   output logic [N_VOICES-1:0][NOTE_W-1:0]  o_voice_note,
   output logic signed [31:0]               o_num_enabled
);
   localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

   va_state_t                        r_state, w_next;
   logic [IDX_W-1:0]                 r_idx;
   voice_evt_t                       r_evt;
   logic [N_VOICES-1:0]              r_enable, r_reset;
   logic [N_VOICES-1:0][FREQ_W-1:0]  r_freq;
   logic [N_VOICES-1:0][NOTE_W-1:0]  r_note;
   logic [N_VOICES-1:0][AGE_W-1:0]   r_age;
   logic signed [31:0]               r_num;

   logic             w_accept, w_scan_last, w_scan_en, w_apply;
   logic             w_match_vld, w_free_vld;
   logic [IDX_W-1:0] w_match_idx, w_free_idx, w_oldest_idx, w_target;
   logic [31:0]      w_pop;

   // Panic wins over a same-cycle handshake.
   assign w_accept    = evt.evt_valid && evt.evt_ready && !i_all_off;
   assign w_scan_last = (r_idx == IDX_W'(N_VOICES - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          r_state <= ST_IDLE;
      else if (i_all_off) r_state <= ST_IDLE;
      else                r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_next = ST_SCAN;
         ST_SCAN:  if (w_scan_last) w_next = ST_APPLY;
         ST_APPLY: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      evt.evt_ready = (r_state == ST_IDLE);
      w_scan_en     = (r_state == ST_SCAN);
      w_apply       = (r_state == ST_APPLY) && !i_all_off;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_evt <= '0;
         r_idx <= '0;
      end else if (w_accept) begin
         r_evt <= '{on: evt.evt_on, note: evt.evt_note, freq: evt.evt_freq};
         r_idx <= '0;
      end else if (w_scan_en && !w_scan_last) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   voice_allocator_scan_unit #(.IDX_W(IDX_W)) u_scan (
      .clk          (clk),
      .rstn         (rstn),
      .i_clear      (w_accept),
      .i_step       (w_scan_en),
      .i_idx        (r_idx),
      .i_cur_enabled(r_enable[r_idx]),
      .i_cur_match  (r_enable[r_idx] && (r_note[r_idx] == r_evt.note)),
      .i_cur_age    (r_age[r_idx]),
      .o_match_vld  (w_match_vld),
      .o_match_idx  (w_match_idx),
      .o_free_vld   (w_free_vld),
      .o_free_idx   (w_free_idx),
      .o_oldest_idx (w_oldest_idx)
   );

   assign w_target = w_match_vld ? w_match_idx : (w_free_vld ? w_free_idx : w_oldest_idx);

   // Reset pulse is only ever set alongside enable, so the oscillator never sees it alone.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_enable <= '0;
         r_reset  <= '0;
         r_freq   <= '0;
         r_note   <= '0;
         r_age    <= '0;
      end else if (i_all_off) begin
         r_enable <= '0;
         r_reset  <= '0;
         r_age    <= '0;
      end else begin
         r_reset <= '0;
         if (w_apply) begin
            if (r_evt.on) begin
               for (int i = 0; i < N_VOICES; i++) begin
                  if (IDX_W'(i) == w_target) begin
                     r_enable[i] <= 1'b1;
                     r_reset[i]  <= 1'b1;
                     r_freq[i]   <= r_evt.freq;
                     r_note[i]   <= r_evt.note;
                     r_age[i]    <= '0;
                  end else if (r_enable[i]) begin
                     r_age[i] <= age_inc(r_age[i]);
                  end
               end
            end else if (w_match_vld) begin
               r_enable[w_match_idx] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N_VOICES; i++) w_pop = w_pop + 32'(r_enable[i]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_num <= '0;
      else       r_num <= signed'(w_pop);
   end

   assign o_voice_enable = r_enable;
   assign o_voice_reset  = r_reset;
   assign o_voice_freq   = r_freq;
   assign o_voice_note   = r_note;
   assign o_num_enabled  = r_num;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, retrigger, note-off, panic and steal.
module tb_voice_allocator;
   import voice_allocator_pkg::*;

   localparam int N = N_OSCILLATORS;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic all_off = 1'b0;
   logic [N-1:0]              en, vrst, pre_en;
   logic [N-1:0][FREQ_W-1:0]  vfreq;
   logic [N-1:0][NOTE_W-1:0]  vnote;
   logic signed [31:0]        num;
   logic                      pre_rdy;
   int total = 0;
   int bad = 0;

   voice_allocator_if bus();

   voice_allocator #(.N_VOICES(N)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .evt           (bus),
      .i_all_off     (all_off),
      .o_voice_enable(en),
      .o_voice_reset (vrst),
      .o_voice_freq  (vfreq),
      .o_voice_note  (vnote),
      .o_num_enabled (num)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   function automatic logic [FREQ_W-1:0] fx(input real r);
      return FREQ_W'($rtoi(r * (2.0 ** FIXED_POINT)));
   endfunction

   // Sends one event; returns at the negedge right after the apply edge.
   // pre_en/pre_rdy hold the view one cycle before outputs are due.
   task automatic run_evt(input logic on, input logic [NOTE_W-1:0] note, input logic [FREQ_W-1:0] f);
      int n = 0;
      bus.evt_valid = 1'b1; bus.evt_on = on; bus.evt_note = note; bus.evt_freq = f;
      while (!bus.evt_ready && n < 20) begin @(negedge clk); n++; end
      total++;
      if (!bus.evt_ready) begin bad++; $display("FAIL accept_timeout ready=%b want=1", bus.evt_ready); end
      @(posedge clk); @(negedge clk);
      bus.evt_valid = 1'b0;
      repeat (N) @(posedge clk);
      @(negedge clk);
      pre_en = en; pre_rdy = bus.evt_ready;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset;
      bus.evt_valid = 1'b0; bus.evt_on = 1'b0; bus.evt_note = '0; bus.evt_freq = '0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL reset_en got=%b want=0000", en); end
      total++; if (vrst !== 4'b0000) begin bad++; $display("FAIL reset_vrst got=%b want=0000", vrst); end
      total++; if (num !== 0) begin bad++; $display("FAIL reset_num got=%0d want=0", num); end
      total++; if (bus.evt_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.evt_ready); end
      rstn = 1'b1;
      @(negedge clk);
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL idle_en got=%b want=0000", en); end
   endtask

   task automatic test_note_on;
      logic [NOTE_W-1:0] nt [3];
      logic [FREQ_W-1:0] fq [3];
      nt[0] = 7'd69; nt[1] = 7'd64; nt[2] = 7'd61;
      fq[0] = fx(440.0); fq[1] = fx(329.63); fq[2] = fx(277.18);
      for (int i = 0; i < 3; i++) begin
         run_evt(1'b1, nt[i], fq[i]);
         total++; if (pre_rdy !== 1'b0) begin bad++; $display("FAIL on%0d_busy ready=%b want=0", i, pre_rdy); end
         total++; if (pre_en !== 4'((1 << i) - 1)) begin bad++; $display("FAIL on%0d_latency en=%b want=%b", i, pre_en, 4'((1 << i) - 1)); end
         total++; if (en !== 4'((1 << (i + 1)) - 1)) begin bad++; $display("FAIL on%0d_en got=%b want=%b", i, en, 4'((1 << (i + 1)) - 1)); end
         total++; if (vrst !== 4'(1 << i)) begin bad++; $display("FAIL on%0d_vrst got=%b want=%b", i, vrst, 4'(1 << i)); end
         total++; if (vfreq[i] !== fq[i]) begin bad++; $display("FAIL on%0d_freq got=%0d want=%0d", i, vfreq[i], fq[i]); end
         total++; if (vnote[i] !== nt[i]) begin bad++; $display("FAIL on%0d_note got=%0d want=%0d", i, vnote[i], nt[i]); end
         total++; if (bus.evt_ready !== 1'b1) begin bad++; $display("FAIL on%0d_ready got=%b want=1", i, bus.evt_ready); end
         @(negedge clk);
         total++; if (vrst !== 4'b0000) begin bad++; $display("FAIL on%0d_pulse got=%b want=0000", i, vrst); end
         total++; if (num !== i + 1) begin bad++; $display("FAIL on%0d_num got=%0d want=%0d", i, num, i + 1); end
      end
   endtask

   task automatic test_retrigger;
      run_evt(1'b1, 7'd69, fx(440.5));
      total++; if (vrst !== 4'b0001) begin bad++; $display("FAIL retrig_vrst got=%b want=0001", vrst); end
      total++; if (en !== 4'b0111) begin bad++; $display("FAIL retrig_en got=%b want=0111", en); end
      total++; if (vfreq[0] !== fx(440.5)) begin bad++; $display("FAIL retrig_freq got=%0d want=%0d", vfreq[0], fx(440.5)); end
      @(negedge clk);
      total++; if (num !== 3) begin bad++; $display("FAIL retrig_num got=%0d want=3", num); end
   endtask

   task automatic test_note_off;
      run_evt(1'b0, 7'd64, '0);
      total++; if (en !== 4'b0101) begin bad++; $display("FAIL off64_en got=%b want=0101", en); end
      total++; if (vrst !== 4'b0000) begin bad++; $display("FAIL off64_vrst got=%b want=0000", vrst); end
      @(negedge clk);
      total++; if (num !== 2) begin bad++; $display("FAIL off64_num got=%0d want=2", num); end
      run_evt(1'b0, 7'd50, '0);
      total++; if (en !== 4'b0101) begin bad++; $display("FAIL off50_en got=%b want=0101", en); end
      @(negedge clk);
      total++; if (num !== 2) begin bad++; $display("FAIL off50_num got=%0d want=2", num); end
   endtask

   task automatic test_all_off;
      bus.evt_valid = 1'b1; bus.evt_on = 1'b1; bus.evt_note = 7'd90; bus.evt_freq = fx(1000.0);
      @(posedge clk); @(negedge clk);
      bus.evt_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      total++; if (bus.evt_ready !== 1'b0) begin bad++; $display("FAIL panic_inscan ready=%b want=0", bus.evt_ready); end
      all_off = 1'b1;
      @(posedge clk); @(negedge clk);
      all_off = 1'b0;
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL panic_en got=%b want=0000", en); end
      total++; if (vrst !== 4'b0000) begin bad++; $display("FAIL panic_vrst got=%b want=0000", vrst); end
      total++; if (bus.evt_ready !== 1'b1) begin bad++; $display("FAIL panic_ready got=%b want=1", bus.evt_ready); end
      repeat (N + 2) @(posedge clk);
      @(negedge clk);
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL panic_dropped en=%b want=0000", en); end
      total++; if (num !== 0) begin bad++; $display("FAIL panic_num got=%0d want=0", num); end
      // Panic in the same cycle as a handshake must block the accept.
      bus.evt_valid = 1'b1; all_off = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.evt_valid = 1'b0; all_off = 1'b0;
      total++; if (bus.evt_ready !== 1'b1) begin bad++; $display("FAIL panic_vs_accept ready=%b want=1", bus.evt_ready); end
      repeat (N + 2) @(posedge clk);
      @(negedge clk);
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL panic_vs_accept_en got=%b want=0000", en); end
   endtask

   task automatic test_steal;
      logic [NOTE_W-1:0] nt [4];
      nt[0] = 7'd60; nt[1] = 7'd62; nt[2] = 7'd64; nt[3] = 7'd67;
      for (int i = 0; i < 4; i++) run_evt(1'b1, nt[i], fx(200.0 + 10.0 * i));
      @(negedge clk);
      total++; if (en !== 4'b1111) begin bad++; $display("FAIL fill_en got=%b want=1111", en); end
      total++; if (num !== 4) begin bad++; $display("FAIL fill_num got=%0d want=4", num); end
      run_evt(1'b1, 7'd80, fx(830.61));
      total++; if (vrst !== 4'b0001) begin bad++; $display("FAIL steal80_vrst got=%b want=0001", vrst); end
      total++; if (vnote[0] !== 7'd80) begin bad++; $display("FAIL steal80_note got=%0d want=80", vnote[0]); end
      total++; if (vfreq[0] !== fx(830.61)) begin bad++; $display("FAIL steal80_freq got=%0d want=%0d", vfreq[0], fx(830.61)); end
      total++; if (en !== 4'b1111) begin bad++; $display("FAIL steal80_en got=%b want=1111", en); end
      // Voice 1 is now the oldest (v0 just reset to age 0).
      run_evt(1'b1, 7'd81, fx(880.0));
      total++; if (vrst !== 4'b0010) begin bad++; $display("FAIL steal81_vrst got=%b want=0010", vrst); end
      total++; if (vnote[1] !== 7'd81) begin bad++; $display("FAIL steal81_note got=%0d want=81", vnote[1]); end
      total++; if (vnote[0] !== 7'd80) begin bad++; $display("FAIL steal81_keep got=%0d want=80", vnote[0]); end
      @(negedge clk);
      total++; if (num !== 4) begin bad++; $display("FAIL steal_num got=%0d want=4", num); end
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_retrigger();
      test_note_off();
      test_all_off();
      test_steal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
